module_rr_sched_4ch: RTL and testbench
======================================

// Module: module_rr_sched_4ch
// PURPOSE
// - Upstream feeder of the 16-bit 4:1 bus mux: captures four independent producer channels into
//   one-entry holding registers and drives the mux data inputs plus a registered 2-bit select.
// - Round-robin arbitration among full channels; valid/ready handshake on each input and on the output.
// - Downstream consumer samples the mux output when valid_o && ready_i.
// PARAMETERS
// - BUS_WIDTH  16  width of each channel data bus and of a_o..d_o
// - CNT_WIDTH  8   width of transfer counter xfer_cnt_o (optional feature only)
// PORTS
// - clk_i       in   1          single clock, all state updates on rising edge
// - rst_i       in   1          synchronous, active-high reset
// - a_i..d_i    in   BUS_WIDTH  channel 0..3 producer data
// - valid_i     in   4          bit k: channel k data valid
// - ready_o     out  4          bit k: channel k holding register can accept
// - a_o..d_o    out  BUS_WIDTH  holding registers 0..3, wired to mux a_i..d_i
// - sel_o       out  2          registered grant, wired to mux sel_i
// - valid_o     out  1          granted holding register is full; mux output valid
// - ready_i     in   1          downstream accepts mux output
// - xfer_cnt_o  out  CNT_WIDTH  completed output transfers (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_i=1 at edge): full[3:0]=0, a_o..d_o=0, sel_o=0, valid_o=0, last_grant=3, state=IDLE,
//   xfer_cnt_o=0. Reset mid-transfer discards all held data; no output handshake completes that cycle.
// - Input handshake: load_k = valid_i[k] && ready_o[k]; on load_k, holding reg k <= data, full[k] <= 1.
// - ready_o[k] = ~full[k] | (out_xfer && sel_o==k)  (combinational; drained slot refills same cycle).
// - out_xfer = valid_o && ready_i. On out_xfer: full[sel_o] <= 0 unless load_k on same slot (then stays 1).
// - Holding reg k is never written while full[k] && !(out_xfer && sel_o==k): data stable under valid.
// - Arbitration: pick first k with full[k]=1 searching last_grant+1, +2, +3, +4 (mod 4, 2-bit wrap 3->0).
//   Uses registered full flags only (data loaded this cycle is not eligible until next cycle).
// - FSM states:
//   IDLE:  valid_o=0. If any full[k]: sel_o<=winner, last_grant<=winner, valid_o<=1, ->GRANT. Else stay.
//   GRANT: valid_o=1, sel_o held constant while !ready_i (no re-arbitration, no glitch on sel_o).
//          On out_xfer: arbitrate over full & ~onehot(sel_o); if winner exists sel_o<=winner,
//          last_grant<=winner, stay GRANT (back-to-back, 1 transfer/cycle); else valid_o<=0, ->IDLE.
// - Latency: load at edge t -> valid_o=1 at edge t+1 (if IDLE); best-case throughput 1 word/cycle.
// - Fairness: with all four channels continuously full and ready_i=1, grant order 0,1,2,3,0,...
// - Slot drained and refilled in same cycle is eligible only after the other full slots (pointer moved).
// - valid_o never drops without out_xfer or reset.
// CONFIGURATION
// - Macro RR_SCHED_XFER_CNT_EN:
//   defined:  xfer_cnt_o increments on every out_xfer, saturates at 2^CNT_WIDTH-1, cleared by rst_i.
//   undefined: counter logic not compiled; xfer_cnt_o tied to 0. Port list identical in both builds.
// TESTING
// - Reset: rst_i=1 two cycles with valid_i=4'hF -> ready_o=4'hF, valid_o=0, sel_o=0, a_o..d_o=0.
// - Single: valid_i=4'b0100, c_i=16'hBEEF one cycle, ready_i=1 -> next cycle valid_o=1, sel_o=2,
//   c_o=16'hBEEF; following cycle valid_o=0, ready_o[2]=1.
// - Round-robin: all four loaded (A1,B2,C3,D4), ready_i=1 -> sel_o 0,1,2,3 on consecutive cycles,
//   valid_o=1 for exactly 4 cycles.
// - Backpressure: ch1 full, ready_i=0 for 5 cycles while valid_i[1]=1 new data -> sel_o=1 stable,
//   b_o unchanged, ready_o[1]=0; ready_i=1 -> transfer, b_o loads new data same edge.
// - Drain/refill + fairness: ch0,ch3 full, grant ch0, ch0 refilled on out_xfer -> next sel_o=3, then 0.
// - Counter (macro on, CNT_WIDTH=4): 20 transfers -> xfer_cnt_o=15; macro off -> xfer_cnt_o=0 always.

Source files
------------

// File: rtl/module_rr_sched_4ch.sv
// Four one-entry channel holding registers feeding a 4:1 bus mux, round-robin select. Optional counter: RR_SCHED_XFER_CNT_EN.
// Latency: load at edge t -> valid_o at edge t+1; up to one word per cycle out.
// Backpressure: sel_o/valid_o held while !ready_i; a full slot stalls its producer until drained.
module module_rr_sched_4ch #(
    parameter int BUS_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    input  logic [BUS_WIDTH-1:0] c_i,
    input  logic [BUS_WIDTH-1:0] d_i,
    input  logic [3:0]           valid_i,
    output logic [3:0]           ready_o,
    output logic [BUS_WIDTH-1:0] a_o,
    output logic [BUS_WIDTH-1:0] b_o,
    output logic [BUS_WIDTH-1:0] c_o,
    output logic [BUS_WIDTH-1:0] d_o,
    output logic [1:0]           sel_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_nxt;
    logic [3:0]           full;
    logic [1:0]           last_grant, last_grant_nxt, sel_nxt;
    logic                 valid_nxt;
    logic                 out_xfer;
    logic [3:0]           drain;
    logic [3:0]           load;
    logic [2:0]           pick;
    logic [BUS_WIDTH-1:0] din  [4];
    logic [BUS_WIDTH-1:0] hold [4];

    // Returns {found, index}: first set bit of req searching last+1 .. last+4 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!r[2] && req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign din[0] = a_i;
    assign din[1] = b_i;
    assign din[2] = c_i;
    assign din[3] = d_i;
    assign a_o    = hold[0];
    assign b_o    = hold[1];
    assign c_o    = hold[2];
    assign d_o    = hold[3];

    assign out_xfer = valid_o && ready_i;
    assign drain    = out_xfer ? (4'b0001 << sel_o) : 4'b0000;
    assign ready_o  = ~full | drain;
    assign load     = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full <= '0;
            for (int k = 0; k < 4; k++) hold[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    hold[k] <= din[k];
                    full[k] <= 1'b1;
                end else if (drain[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    // Only registered full flags compete, so a slot loaded this cycle waits a cycle.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel_o;
        last_grant_nxt = last_grant;
        valid_nxt      = valid_o;
        pick           = '0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                pick      = rr_pick(full, last_grant);
                if (pick[2]) begin
                    sel_nxt        = pick[1:0];
                    last_grant_nxt = pick[1:0];
                    valid_nxt      = 1'b1;
                    state_nxt      = GRANT;
                end
            end
            GRANT: begin
                if (out_xfer) begin
                    pick = rr_pick(full & ~drain, last_grant);
                    if (pick[2]) begin
                        sel_nxt        = pick[1:0];
                        last_grant_nxt = pick[1:0];
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sel_o      <= 2'd0;
            valid_o    <= 1'b0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_nxt;
            sel_o      <= sel_nxt;
            valid_o    <= valid_nxt;
            last_grant <= last_grant_nxt;
        end
    end

`ifdef RR_SCHED_XFER_CNT_EN
    logic [CNT_WIDTH-1:0] xfer_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_cnt <= '0;
        end else if (out_xfer && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
        end
    end

    assign xfer_cnt_o = xfer_cnt;
`else
    assign xfer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_module_rr_sched_4ch.sv
// Directed bench for module_rr_sched_4ch: reset, single word, round-robin, backpressure, refill fairness, counter.
module tb_module_rr_sched_4ch;

    localparam int BW = 16;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [BW-1:0] a_i, b_i, c_i, d_i;
    logic [3:0]    valid_i;
    logic [3:0]    ready_o;
    logic [BW-1:0] a_o, b_o, c_o, d_o;
    logic [1:0]    sel_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] xfer_cnt_o;

    int checks = 0;
    int errors = 0;
    int xfers;

    module_rr_sched_4ch #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
        .sel_o(sel_o), .valid_o(valid_o), .ready_i(ready_i),
        .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; ready_i = 1'b0; valid_i = 4'hF;
        a_i = 16'h1111; b_i = 16'h2222; c_i = 16'h3333; d_i = 16'h4444;

        // Reset holds everything empty even with all producers valid.
        tick(); tick();
        chk("rst_ready", 32'(ready_o), 32'hF);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_sel", 32'(sel_o), 32'h0);
        chk("rst_data", {a_o | b_o, c_o | d_o}, 32'h0);
        chk("rst_cnt", 32'(xfer_cnt_o), 32'h0);

        // Single word on channel 2.
        rst_i = 1'b0; ready_i = 1'b1; valid_i = 4'b0100; c_i = 16'hBEEF;
        tick();
        valid_i = 4'b0000;
        chk("single_load_valid", 32'(valid_o), 32'h0);
        chk("single_load_ready", 32'(ready_o), 32'hF & ~32'h4);
        tick();
        chk("single_valid", 32'(valid_o), 32'h1);
        chk("single_sel", 32'(sel_o), 32'h2);
        chk("single_data", 32'(c_o), 32'hBEEF);
        tick();
        chk("single_done_valid", 32'(valid_o), 32'h0);
        chk("single_done_ready", 32'(ready_o), 32'hF);

        // Round-robin from a fresh pointer.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        a_i = 16'h00A1; b_i = 16'h00B2; c_i = 16'h00C3; d_i = 16'h00D4;
        valid_i = 4'hF; ready_i = 1'b1;
        tick();
        valid_i = 4'h0;
        chk("rr_loaded_valid", 32'(valid_o), 32'h0);
        tick();
        chk("rr_sel0", {30'd0, sel_o}, 32'd0);
        chk("rr_v0", 32'(valid_o), 32'h1);
        chk("rr_a", 32'(a_o), 32'h00A1);
        tick();
        chk("rr_sel1", {30'd0, sel_o}, 32'd1);
        chk("rr_b", 32'(b_o), 32'h00B2);
        tick();
        chk("rr_sel2", {30'd0, sel_o}, 32'd2);
        chk("rr_c", 32'(c_o), 32'h00C3);
        tick();
        chk("rr_sel3", {30'd0, sel_o}, 32'd3);
        chk("rr_v3", 32'(valid_o), 32'h1);
        chk("rr_d", 32'(d_o), 32'h00D4);
        tick();
        chk("rr_end_valid", 32'(valid_o), 32'h0);
`ifdef RR_SCHED_XFER_CNT_EN
        chk("rr_cnt", 32'(xfer_cnt_o), 32'd4);
`else
        chk("rr_cnt", 32'(xfer_cnt_o), 32'd0);
`endif

        // Backpressure on channel 1 with a second word waiting upstream.
        ready_i = 1'b0; valid_i = 4'b0010; b_i = 16'h1111;
        tick();
        b_i = 16'h2222;
        chk("bp_ready_full", 32'(ready_o[1]), 32'h0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_sel", 32'(sel_o), 32'h1);
            chk("bp_valid", 32'(valid_o), 32'h1);
            chk("bp_hold", 32'(b_o), 32'h1111);
            chk("bp_ready", 32'(ready_o[1]), 32'h0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_ready_drain", 32'(ready_o[1]), 32'h1);
        tick();
        valid_i = 4'b0000;
        chk("bp_refill_data", 32'(b_o), 32'h2222);
        chk("bp_refill_valid", 32'(valid_o), 32'h0);
        tick();
        chk("bp_second_valid", 32'(valid_o), 32'h1);
        chk("bp_second_sel", 32'(sel_o), 32'h1);
        tick();
        chk("bp_empty", 32'(ready_o), 32'hF);
        chk("bp_end_valid", 32'(valid_o), 32'h0);

        // Drain/refill of channel 0 must yield to channel 3 first.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        ready_i = 1'b0; valid_i = 4'b1001; a_i = 16'hA0A0; d_i = 16'hD0D0;
        tick();
        valid_i = 4'b0000;
        tick();
        chk("dr_first_sel", 32'(sel_o), 32'h0);
        ready_i = 1'b1; valid_i = 4'b0001; a_i = 16'hA1A1;
        #1;
        chk("dr_ready0", 32'(ready_o), 32'b0111);
        tick();
        valid_i = 4'b0000;
        chk("dr_next_sel", 32'(sel_o), 32'h3);
        chk("dr_refill", 32'(a_o), 32'hA1A1);
        chk("dr_valid", 32'(valid_o), 32'h1);
        tick();
        chk("dr_back_sel", 32'(sel_o), 32'h0);
        chk("dr_back_valid", 32'(valid_o), 32'h1);
        tick();
        chk("dr_end_valid", 32'(valid_o), 32'h0);

        // Reset while a transfer is offered discards the word.
        ready_i = 1'b0; valid_i = 4'b0100; c_i = 16'hCCCC;
        tick();
        valid_i = 4'b0000;
        tick();
        chk("mr_pre_valid", 32'(valid_o), 32'h1);
        ready_i = 1'b1; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mr_valid", 32'(valid_o), 32'h0);
        chk("mr_ready", 32'(ready_o), 32'hF);
        chk("mr_data", 32'(c_o), 32'h0);
        chk("mr_cnt", 32'(xfer_cnt_o), 32'h0);

        // Counter: 20 transfers on a 4-bit counter.
        valid_i = 4'b0001; a_i = 16'h5A5A; ready_i = 1'b1; xfers = 0;
        for (int n = 0; n < 200 && xfers < 20; n++) begin
            if (valid_o && ready_i) xfers++;
            tick();
        end
        valid_i = 4'b0000;
        chk("cnt_xfers_seen", 32'(xfers), 32'd20);
`ifdef RR_SCHED_XFER_CNT_EN
        chk("cnt_sat", 32'(xfer_cnt_o), 32'd15);
`else
        chk("cnt_off", 32'(xfer_cnt_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
